s_axi_lite_wr_bridge: RTL

- Next-generation AXI4-Lite write slave for the sequencer control register file.
- Generalises the fixed two-bank write decoder to a parametrised bank/row/register address split. Adds:
  - AW and W accepted in either order.
  - Backpressured write-request port toward the register banks.
  - SLVERR on unmapped or read-only targets, and on locked banks.
  - Saturating error counter.
- Sits between the AXI-Lite interconnect and the bank0/bank1 register blocks.

---
 rtl/seq_axi_pkg.sv | 28 ++
 rtl/s_axi_lite_wr_bridge_if.sv | 28 ++
 rtl/s_axi_wr_decode.sv | 50 +++++
 rtl/s_axi_lite_wr_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_axi_pkg.sv
// Shared types and constants for the sequencer control AXI-Lite slaves.
package seq_axi_pkg;

   // Write response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write-path transaction state
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } wr_state_e;

   // Default address split and datapath widths
   localparam int DEF_ADDR_WIDTH     = 16;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_BANK_SEL_WIDTH = 2;
   localparam int DEF_ROW_WIDTH      = 8;
   localparam int DEF_REG_WIDTH      = 4;
   localparam int DEF_NUM_BANKS      = 2;
   localparam int DEF_ERR_CNT_WIDTH  = 8;

   // Bank map shared with the read slave; bank0 occupies the LSBs
   localparam logic [31:0] DEF_BANK_WR_MASK   = {16'h01FF, 16'h01F9};
   localparam logic [15:0] DEF_BANK_ROW_LIMIT = {8'd8, 8'd1};

endpackage

// File: rtl/s_axi_lite_wr_bridge_if.sv
// AXI4-Lite write channels (AW, W, B) between interconnect and slave.
interface s_axi_lite_wr_bridge_if
   import seq_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   logic [1:0]              S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID
   );
endinterface

// File: rtl/s_axi_wr_decode.sv
// Combinational bank/row/register address decode with access check.
// Shared by the write bridge and the future read path.
module s_axi_wr_decode
   import seq_axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
   parameter int ROW_WIDTH      = DEF_ROW_WIDTH,
   parameter int REG_WIDTH      = DEF_REG_WIDTH,
   parameter int NUM_BANKS      = DEF_NUM_BANKS,
   parameter logic [NUM_BANKS*(2**REG_WIDTH)-1:0] BANK_WR_MASK   = DEF_BANK_WR_MASK,
   parameter logic [NUM_BANKS*ROW_WIDTH-1:0]      BANK_ROW_LIMIT = DEF_BANK_ROW_LIMIT
)(
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [NUM_BANKS-1:0]      bank_lock,
   output logic [BANK_SEL_WIDTH-1:0] bank,
   output logic [ROW_WIDTH-1:0]      row,
   output logic [REG_WIDTH-1:0]      reg_sel,
   output logic                      decode_ok
);
   localparam int REGS_PER_BANK = 2**REG_WIDTH;

   logic [NUM_BANKS-1:0] bank_hit;
   logic [NUM_BANKS-1:0] bank_ok;
   logic                 unused_addr_lsbs;

   assign bank    = addr[ADDR_WIDTH-1 -: BANK_SEL_WIDTH];
   assign row     = addr[REG_WIDTH+2 +: ROW_WIDTH];
   assign reg_sel = addr[2 +: REG_WIDTH];

   // Byte offset within the word carries no meaning for register access
   assign unused_addr_lsbs = ^addr[1:0];

   // Per-bank match and access rules; an unmapped bank index hits no entry
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic [REGS_PER_BANK-1:0] wr_mask;
         logic [ROW_WIDTH-1:0]     row_limit;

         assign wr_mask      = BANK_WR_MASK[gi*REGS_PER_BANK +: REGS_PER_BANK];
         assign row_limit    = BANK_ROW_LIMIT[gi*ROW_WIDTH +: ROW_WIDTH];
         assign bank_hit[gi] = (bank == BANK_SEL_WIDTH'(gi));
         assign bank_ok[gi]  = (row < row_limit) && wr_mask[reg_sel] && !bank_lock[gi];
      end
   endgenerate

   assign decode_ok = |(bank_hit & bank_ok);

endmodule

// File: rtl/s_axi_lite_wr_bridge.sv
// AXI4-Lite write slave for the sequencer control register banks.
// Accepts AW and W in any order, decodes the target, forwards a
// backpressured write request and counts SLVERR responses.
module s_axi_lite_wr_bridge
   import seq_axi_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
   parameter int ROW_WIDTH      = DEF_ROW_WIDTH,
   parameter int REG_WIDTH      = DEF_REG_WIDTH,
   parameter int NUM_BANKS      = DEF_NUM_BANKS,
   parameter logic [NUM_BANKS*(2**REG_WIDTH)-1:0] BANK_WR_MASK   = DEF_BANK_WR_MASK,
   parameter logic [NUM_BANKS*ROW_WIDTH-1:0]      BANK_ROW_LIMIT = DEF_BANK_ROW_LIMIT,
   parameter int ERR_CNT_WIDTH  = DEF_ERR_CNT_WIDTH
)(
   input  logic                      clk,
   input  logic                      reset,
   s_axi_lite_wr_bridge_if.slave     s_axi,
   output logic                      wr_valid,
   input  logic                      wr_ready,
   output logic [BANK_SEL_WIDTH-1:0] wr_bank,
   output logic [ROW_WIDTH-1:0]      wr_row,
   output logic [REG_WIDTH-1:0]      wr_reg,
   output logic [DATA_WIDTH-1:0]     wr_data,
   output logic [DATA_WIDTH/8-1:0]   wr_strb,
   input  logic [NUM_BANKS-1:0]      bank_lock,
   output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);
   localparam int STRB_WIDTH = DATA_WIDTH/8;

   wr_state_e                 state_reg, state_next;
   logic [1:0]                bresp_reg, bresp_next;
   logic [ERR_CNT_WIDTH-1:0]  err_cnt_reg;

   logic                      aw_hold_reg, w_hold_reg;
   logic [ADDR_WIDTH-1:0]     addr_reg;
   logic [DATA_WIDTH-1:0]     data_reg;
   logic [STRB_WIDTH-1:0]     strb_reg;

   logic [BANK_SEL_WIDTH-1:0] wr_bank_reg;
   logic [ROW_WIDTH-1:0]      wr_row_reg;
   logic [REG_WIDTH-1:0]      wr_reg_reg;
   logic [DATA_WIDTH-1:0]     wr_data_reg;
   logic [STRB_WIDTH-1:0]     wr_strb_reg;

   logic                      aw_fire, w_fire, both_ready;
   logic [ADDR_WIDTH-1:0]     addr_cur;
   logic [DATA_WIDTH-1:0]     data_cur;
   logic [STRB_WIDTH-1:0]     strb_cur;

   logic [BANK_SEL_WIDTH-1:0] dec_bank;
   logic [ROW_WIDTH-1:0]      dec_row;
   logic [REG_WIDTH-1:0]      dec_reg;
   logic                      dec_ok;

   // Handshakes only happen in IDLE because the readies are gated by state
   assign aw_fire    = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
   assign w_fire     = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
   assign both_ready = (aw_hold_reg || aw_fire) && (w_hold_reg || w_fire);

   // Held values win; otherwise use whatever is completing this cycle
   assign addr_cur = aw_hold_reg ? addr_reg : s_axi.S_AXI_AWADDR;
   assign data_cur = w_hold_reg  ? data_reg : s_axi.S_AXI_WDATA;
   assign strb_cur = w_hold_reg  ? strb_reg : s_axi.S_AXI_WSTRB;

   s_axi_wr_decode #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .BANK_SEL_WIDTH (BANK_SEL_WIDTH),
      .ROW_WIDTH      (ROW_WIDTH),
      .REG_WIDTH      (REG_WIDTH),
      .NUM_BANKS      (NUM_BANKS),
      .BANK_WR_MASK   (BANK_WR_MASK),
      .BANK_ROW_LIMIT (BANK_ROW_LIMIT)
   ) u_decode (
      .addr      (addr_cur),
      .bank_lock (bank_lock),
      .bank      (dec_bank),
      .row       (dec_row),
      .reg_sel   (dec_reg),
      .decode_ok (dec_ok)
   );

   // State, response code and saturating error count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         bresp_reg   <= RESP_OKAY;
         err_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         bresp_reg <= bresp_next;
         if (state_reg != ST_RESP && state_next == ST_RESP &&
             bresp_next == RESP_SLVERR && err_cnt_reg != '1) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_WIDTH'(1);
         end
      end
   end

   // Next state and response; decode runs once both halves are present
   always_comb begin
      state_next = state_reg;
      bresp_next = bresp_reg;
      case (state_reg)
         ST_IDLE: begin
            if (both_ready) begin
               if (!dec_ok) begin
                  state_next = ST_RESP;
                  bresp_next = RESP_SLVERR;
               end else if (strb_cur == '0) begin
                  // Nothing to write: acknowledge without touching the bank
                  state_next = ST_RESP;
                  bresp_next = RESP_OKAY;
               end else begin
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (wr_ready) begin
               state_next = ST_RESP;
               bresp_next = RESP_OKAY;
            end
         end
         ST_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Capture AW and W independently in IDLE; clear both when decode fires
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aw_hold_reg <= 1'b0;
         w_hold_reg  <= 1'b0;
         addr_reg    <= '0;
         data_reg    <= '0;
         strb_reg    <= '0;
      end else if (state_reg == ST_IDLE) begin
         if (both_ready) begin
            aw_hold_reg <= 1'b0;
            w_hold_reg  <= 1'b0;
         end else begin
            if (aw_fire) begin
               aw_hold_reg <= 1'b1;
               addr_reg    <= s_axi.S_AXI_AWADDR;
            end
            if (w_fire) begin
               w_hold_reg <= 1'b1;
               data_reg   <= s_axi.S_AXI_WDATA;
               strb_reg   <= s_axi.S_AXI_WSTRB;
            end
         end
      end
   end

   // Freeze the request fields on entry to ISSUE so they stay stable under backpressure
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_bank_reg <= '0;
         wr_row_reg  <= '0;
         wr_reg_reg  <= '0;
         wr_data_reg <= '0;
         wr_strb_reg <= '0;
      end else if (state_reg == ST_IDLE && state_next == ST_ISSUE) begin
         wr_bank_reg <= dec_bank;
         wr_row_reg  <= dec_row;
         wr_reg_reg  <= dec_reg;
         wr_data_reg <= data_cur;
         wr_strb_reg <= strb_cur;
      end
   end

   // Outputs are functions of registered state only
   always_comb begin
      s_axi.S_AXI_AWREADY = (state_reg == ST_IDLE) && !aw_hold_reg;
      s_axi.S_AXI_WREADY  = (state_reg == ST_IDLE) && !w_hold_reg;
      s_axi.S_AXI_BVALID  = (state_reg == ST_RESP);
      s_axi.S_AXI_BRESP   = bresp_reg;
      wr_valid            = (state_reg == ST_ISSUE);
      wr_bank             = wr_bank_reg;
      wr_row              = wr_row_reg;
      wr_reg              = wr_reg_reg;
      wr_data             = wr_data_reg;
      wr_strb             = wr_strb_reg;
      err_cnt             = err_cnt_reg;
   end

endmodule
